// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I decode types for the decode stage.
// Holds the operation enum, opcode/funct constants, the decoded entry
// struct and the skid buffer state type.
package instruction_utils;

   typedef enum logic [5:0] {
      INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
      INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
      INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
      INSTR_SB, INSTR_SH, INSTR_SW,
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
      INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
      INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
      INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
      INSTR_ILLEGAL
   } rv32i_instr_e;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   // ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   // branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   // load/store width funct3
   localparam logic [2:0] F3_B    = 3'b000;
   localparam logic [2:0] F3_H    = 3'b001;
   localparam logic [2:0] F3_W    = 3'b010;
   localparam logic [2:0] F3_BU   = 3'b100;
   localparam logic [2:0] F3_HU   = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
   } instr_fmt_e;

   typedef struct packed {
      rv32i_instr_e instr;
      logic [4:0]   rs1_addr;
      logic [4:0]   rs2_addr;
      logic [4:0]   rd_addr;
      logic [31:0]  imm;
      logic [31:0]  pc;
      logic         illegal;
   } decoded_instr_t;

   localparam decoded_instr_t DECODED_RESET = '{
      instr:    INSTR_ILLEGAL,
      rs1_addr: 5'd0,
      rs2_addr: 5'd0,
      rd_addr:  5'd0,
      imm:      32'd0,
      pc:       32'd0,
      illegal:  1'b0
   };

   typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;

endpackage

// File: rtl/instr_decode_stage_skid.sv
// Two-entry skid buffer with flush for the decode stage output.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data upstream;
// flush discards everything held and the word presented this cycle;
// out_valid/out_ready/out_data downstream.
//
// state      | meaning
// SKID_EMPTY | nothing held
// SKID_ONE   | main register holds the output entry
// SKID_TWO   | main holds output, skid holds the next entry
module decode_skid_buffer
   import instruction_utils::*;
#(
   parameter int unsigned    W       = 8,
   parameter bit             EN_SKID = 1'b1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, skid_q;
   logic         in_ready_q;
   logic         accept, drain;
   logic         load_main, load_skid, main_from_skid;

   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   // Without the skid entry the ready has to look at out_ready directly.
   assign in_ready  = EN_SKID ? in_ready_q : (!out_valid || out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = SKID_EMPTY;
      end else begin
         case (state_q)
            SKID_EMPTY: begin
               if (accept) begin
                  state_d   = SKID_ONE;
                  load_main = 1'b1;
               end
            end
            SKID_ONE: begin
               if (accept && drain) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_d   = SKID_TWO;
                  load_skid = 1'b1;
               end else if (drain) begin
                  state_d = SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (drain) begin
                  state_d        = SKID_ONE;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = SKID_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SKID_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= RST_VAL;
         skid_q     <= RST_VAL;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != SKID_TWO);
         if (load_main)           main_q <= in_data;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into
// operation, register indices and immediate, registered through a skid buffer.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_instr/in_pc from
// fetch; flush from execute take_branch; out_valid/out_ready and the decoded
// out_instr, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm, out_pc,
// out_illegal to execute.
module instr_decode_stage
   import instruction_utils::*;
#(
   parameter bit EN_SKID = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   input  logic [31:0]  in_pc,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output rv32i_instr_e out_instr,
   output logic [4:0]   out_rs1_addr,
   output logic [4:0]   out_rs2_addr,
   output logic [4:0]   out_rd_addr,
   output logic [31:0]  out_imm,
   output logic [31:0]  out_pc,
   output logic         out_illegal
);

   logic [6:0]     opcode, funct7;
   logic [2:0]     funct3;
   rv32i_instr_e   op;
   instr_fmt_e     fmt;
   decoded_instr_t dec, held;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // Full 7-bit opcode match also rejects compressed and all-zero words.
   always_comb begin
      op  = INSTR_ILLEGAL;
      fmt = FMT_R;
      case (opcode)
         LUI:   begin op = INSTR_LUI;   fmt = FMT_U; end
         AUIPC: begin op = INSTR_AUIPC; fmt = FMT_U; end
         JAL:   begin op = INSTR_JAL;   fmt = FMT_J; end
         JALR: begin
            fmt = FMT_I;
            if (funct3 == 3'b000) op = INSTR_JALR;
         end
         BRANCH: begin
            fmt = FMT_B;
            case (funct3)
               F3_BEQ:  op = INSTR_BEQ;
               F3_BNE:  op = INSTR_BNE;
               F3_BLT:  op = INSTR_BLT;
               F3_BGE:  op = INSTR_BGE;
               F3_BLTU: op = INSTR_BLTU;
               F3_BGEU: op = INSTR_BGEU;
               default: op = INSTR_ILLEGAL;
            endcase
         end
         LOAD: begin
            fmt = FMT_I;
            case (funct3)
               F3_B:    op = INSTR_LB;
               F3_H:    op = INSTR_LH;
               F3_W:    op = INSTR_LW;
               F3_BU:   op = INSTR_LBU;
               F3_HU:   op = INSTR_LHU;
               default: op = INSTR_ILLEGAL;
            endcase
         end
         STORE: begin
            fmt = FMT_S;
            case (funct3)
               F3_B:    op = INSTR_SB;
               F3_H:    op = INSTR_SH;
               F3_W:    op = INSTR_SW;
               default: op = INSTR_ILLEGAL;
            endcase
         end
         OP_IMM: begin
            fmt = FMT_I;
            case (funct3)
               F3_ADD:  op = INSTR_ADDI;
               F3_SLT:  op = INSTR_SLTI;
               F3_SLTU: op = INSTR_SLTIU;
               F3_XOR:  op = INSTR_XORI;
               F3_OR:   op = INSTR_ORI;
               F3_AND:  op = INSTR_ANDI;
               // funct7 compare covers the reserved shamt[5] bit too
               F3_SLL: begin
                  fmt = FMT_SH;
                  if (funct7 == F7_BASE) op = INSTR_SLLI;
               end
               F3_SR: begin
                  fmt = FMT_SH;
                  if (funct7 == F7_BASE)     op = INSTR_SRLI;
                  else if (funct7 == F7_ALT) op = INSTR_SRAI;
               end
               default: op = INSTR_ILLEGAL;
            endcase
         end
         OP: begin
            fmt = FMT_R;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  op = INSTR_ADD;
                  F3_SLL:  op = INSTR_SLL;
                  F3_SLT:  op = INSTR_SLT;
                  F3_SLTU: op = INSTR_SLTU;
                  F3_XOR:  op = INSTR_XOR;
                  F3_SR:   op = INSTR_SRL;
                  F3_OR:   op = INSTR_OR;
                  F3_AND:  op = INSTR_AND;
                  default: op = INSTR_ILLEGAL;
               endcase
            end else if (funct7 == F7_ALT) begin
               if (funct3 == F3_ADD)     op = INSTR_SUB;
               else if (funct3 == F3_SR) op = INSTR_SRA;
            end
         end
         default: op = INSTR_ILLEGAL;
      endcase
   end

   always_comb begin
      dec          = DECODED_RESET;
      dec.instr    = op;
      dec.pc       = in_pc;
      dec.illegal  = (op == INSTR_ILLEGAL);
      if (op != INSTR_ILLEGAL) begin
         case (fmt)
            FMT_R: begin
               dec.rd_addr  = in_instr[11:7];
               dec.rs1_addr = in_instr[19:15];
               dec.rs2_addr = in_instr[24:20];
            end
            FMT_I: begin
               dec.rd_addr  = in_instr[11:7];
               dec.rs1_addr = in_instr[19:15];
               dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            FMT_SH: begin
               dec.rd_addr  = in_instr[11:7];
               dec.rs1_addr = in_instr[19:15];
               dec.imm      = {27'd0, in_instr[24:20]};
            end
            FMT_S: begin
               dec.rs1_addr = in_instr[19:15];
               dec.rs2_addr = in_instr[24:20];
               dec.imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            FMT_B: begin
               dec.rs1_addr = in_instr[19:15];
               dec.rs2_addr = in_instr[24:20];
               dec.imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            end
            FMT_U: begin
               dec.rd_addr  = in_instr[11:7];
               dec.imm      = {in_instr[31:12], 12'd0};
            end
            FMT_J: begin
               dec.rd_addr  = in_instr[11:7];
               dec.imm      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            end
            default: dec.rd_addr = 5'd0;
         endcase
      end
   end

   decode_skid_buffer #(
      .W       ($bits(decoded_instr_t)),
      .EN_SKID (EN_SKID),
      .RST_VAL (DECODED_RESET)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (held)
   );

   assign out_instr    = held.instr;
   assign out_rs1_addr = held.rs1_addr;
   assign out_rs2_addr = held.rs2_addr;
   assign out_rd_addr  = held.rd_addr;
   assign out_imm      = held.imm;
   assign out_pc       = held.pc;
   assign out_illegal  = held.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
   import instruction_utils::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_instr = 32'd0;
   logic [31:0]  in_pc = 32'd0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   rv32i_instr_e out_instr;
   logic [4:0]   out_rs1_addr, out_rs2_addr, out_rd_addr;
   logic [31:0]  out_imm, out_pc;
   logic         out_illegal;

   instr_decode_stage #(.EN_SKID(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_rs1_addr (out_rs1_addr),
      .out_rs2_addr (out_rs2_addr),
      .out_rd_addr  (out_rd_addr),
      .out_imm      (out_imm),
      .out_pc       (out_pc),
      .out_illegal  (out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  instr;
      logic [31:0]  pc;
      rv32i_instr_e op;
      logic [4:0]   rd, rs1, rs2;
      logic [31:0]  imm;
      logic         ill;
   } vec_t;

   vec_t vecs[15];
   vec_t cur_exp;
   vec_t model_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input rv32i_instr_e op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic ill);
      vec_t v;
      v.instr = instr; v.pc = pc; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.ill = ill;
      return v;
   endfunction

   // Occupancy/order model: a FIFO of at most two entries, cleared by flush or reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_q.delete();
      end else if (flush) begin
         model_q.delete();
      end else begin
         automatic bit do_acc = in_valid && (model_q.size() < 2);
         automatic bit do_drn = (model_q.size() > 0) && out_ready;
         if (do_drn) void'(model_q.pop_front());
         if (do_acc) model_q.push_back(cur_exp);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
      end else begin
         chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
         if (model_q.size() > 0 && out_valid) begin
            chk("instr", 32'(out_instr), 32'(model_q[0].op));
            chk("rd", 32'(out_rd_addr), 32'(model_q[0].rd));
            chk("rs1", 32'(out_rs1_addr), 32'(model_q[0].rs1));
            chk("rs2", 32'(out_rs2_addr), 32'(model_q[0].rs2));
            chk("imm", out_imm, model_q[0].imm);
            chk("pc", out_pc, model_q[0].pc);
            chk("illegal", 32'(out_illegal), 32'(model_q[0].ill));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic present(input int i);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      cur_exp  = vecs[i];
   endtask

   task automatic wait_accept();
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         step();
         guard++;
      end while (!acc && guard < 20);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input int i);
      present(i);
      wait_accept();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(32'hFFF00093, 32'h100, INSTR_ADDI,    5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
      vecs[1]  = mk(32'hFE000EE3, 32'h104, INSTR_BEQ,     5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
      vecs[2]  = mk(32'h12345537, 32'h108, INSTR_LUI,     5'd10, 5'd0, 5'd0, 32'h12345000, 1'b0);
      vecs[3]  = mk(32'h00000000, 32'h10C, INSTR_ILLEGAL, 5'd0,  5'd0, 5'd0, 32'h0,        1'b1);
      vecs[4]  = mk(32'h0250D093, 32'h110, INSTR_ILLEGAL, 5'd0,  5'd0, 5'd0, 32'h0,        1'b1);
      vecs[5]  = mk(32'h002081B3, 32'h114, INSTR_ADD,     5'd3,  5'd1, 5'd2, 32'h0,        1'b0);
      vecs[6]  = mk(32'h00512423, 32'h118, INSTR_SW,      5'd0,  5'd2, 5'd5, 32'h8,        1'b0);
      vecs[7]  = mk(32'h001000EF, 32'h11C, INSTR_JAL,     5'd1,  5'd0, 5'd0, 32'h800,      1'b0);
      vecs[8]  = mk(32'h4030D093, 32'h120, INSTR_SRAI,    5'd1,  5'd1, 5'd0, 32'h3,        1'b0);
      vecs[9]  = mk(32'hFF032383, 32'h124, INSTR_LW,      5'd7,  5'd6, 5'd0, 32'hFFFFFFF0, 1'b0);
      vecs[10] = mk(32'h40628233, 32'h128, INSTR_SUB,     5'd4,  5'd5, 5'd6, 32'h0,        1'b0);
      vecs[11] = mk(32'h00000001, 32'h12C, INSTR_ILLEGAL, 5'd0,  5'd0, 5'd0, 32'h0,        1'b1);
      vecs[12] = mk(32'hFFFFF117, 32'h130, INSTR_AUIPC,   5'd2,  5'd0, 5'd0, 32'hFFFFF000, 1'b0);
      vecs[13] = mk(32'h00008067, 32'h134, INSTR_JALR,    5'd0,  5'd1, 5'd0, 32'h0,        1'b0);
      vecs[14] = mk(32'h02009093, 32'h138, INSTR_ILLEGAL, 5'd0,  5'd0, 5'd0, 32'h0,        1'b1);
      cur_exp  = vecs[0];

      // reset values
      step(); step();
      chk("reset_instr", 32'(out_instr), 32'(INSTR_ILLEGAL));
      chk("reset_illegal", 32'(out_illegal), 32'd0);
      chk("reset_imm", out_imm, 32'd0);
      chk("reset_pc", out_pc, 32'd0);
      chk("reset_rd", 32'(out_rd_addr), 32'd0);
      step();
      rst = 1'b0;
      step();

      // streaming at full rate
      for (int i = 0; i < 15; i++) begin
         send(i);
         if (i == 0) begin
            chk("addi_imm", out_imm, 32'hFFFFFFFF);
            chk("addi_rd", 32'(out_rd_addr), 32'd1);
            chk("addi_pc", out_pc, 32'h100);
         end
         if (i == 1) chk("beq_imm", out_imm, 32'hFFFFFFFC);
         if (i == 2) begin
            chk("lui_rd", 32'(out_rd_addr), 32'd10);
            chk("lui_imm", out_imm, 32'h12345000);
         end
         if (i == 4) begin
            chk("srai_bad_illegal", 32'(out_illegal), 32'd1);
            chk("srai_bad_instr", 32'(out_instr), 32'(INSTR_ILLEGAL));
         end
      end
      in_valid = 1'b0;
      step(); step();

      // backpressure: two accepted, third waits
      out_ready = 1'b0;
      send(5);
      send(6);
      present(7);
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_head_instr", 32'(out_instr), 32'(INSTR_ADD));
      step();
      chk("bp_head_pc", out_pc, 32'h114);
      out_ready = 1'b1;
      wait_accept();
      in_valid = 1'b0;
      step(); step(); step();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // flush while two entries held, with a concurrent word
      out_ready = 1'b0;
      send(8);
      send(9);
      present(10);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step(); step();

      // flush with one held and in_ready high
      out_ready = 1'b0;
      send(12);
      present(13);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush1_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();

      // reset mid-stream with two entries held
      out_ready = 1'b0;
      send(0);
      send(1);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_instr", 32'(out_instr), 32'(INSTR_ILLEGAL));
      chk("midrst_pc", out_pc, 32'd0);
      step(); step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      send(2);
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_instr", 32'(out_instr), 32'(INSTR_LUI));
      chk("post_rst_pc", out_pc, 32'h108);
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
